// File: rtl/xor_glitch_filter_pkg.sv
// Shared types, default constants and width helper for the XOR glitch filter.
package xor_filter_pkg;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } filt_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/xor_glitch_filter_if.sv
// Signal bundle between the XOR stage consumer and the filter outputs.
interface xor_glitch_filter_if
    import xor_filter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             f_in;
    logic             f_out;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] toggle_count;
    logic [CNT_W-1:0] glitch_count;

    modport master (
        output f_in,
        input  f_out, rise, fall, toggle_count, glitch_count
    );

    modport slave (
        input  f_in,
        output f_out, rise, fall, toggle_count, glitch_count
    );
endinterface

// File: rtl/xor_glitch_filter_bit_sync.sv
// N-flop synchronizer for a single asynchronous bit, reset to 0.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [N-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= {N{1'b0}};
        end else begin
            sync_r <= {sync_r[N-2:0], d};
        end
    end

    assign q = sync_r[N-1];
endmodule

// File: rtl/xor_glitch_filter.sv
// Synchronizes and debounces the XOR stage output F; the glitch counter is
// built only when XOR_FILTER_GLITCH_CNT_EN is defined (otherwise tied to 0).
module xor_glitch_filter
    import xor_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    xor_glitch_filter_if.slave bus
);
    localparam int CW = clog2(STABLE_CYCLES + 1);

    logic             sync_s;
    logic             diff_s;
    logic             toggle_s;
    filt_state_e      state_r;
    filt_state_e      state_n;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_n;
    logic             f_out_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] toggle_cnt_r;

    bit_sync #(.N(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.f_in),
        .q     (sync_s)
    );

    assign diff_s = sync_s ^ f_out_r;

    // State and stability counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= STABLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // cnt_r counts earlier differing samples; the current one completes the window.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        toggle_s = 1'b0;
        case (state_r)
            STABLE: begin
                cnt_n = {CW{1'b0}};
                if (diff_s) begin
                    if (STABLE_CYCLES == 32'sd1) begin
                        toggle_s = 1'b1;
                    end else begin
                        state_n = PENDING;
                        cnt_n   = CW'(1);
                    end
                end else begin
                    state_n = STABLE;
                end
            end
            PENDING: begin
                if (!diff_s) begin
                    state_n = STABLE;
                    cnt_n   = {CW{1'b0}};
                end else if (cnt_r == CW'(STABLE_CYCLES - 1)) begin
                    toggle_s = 1'b1;
                    state_n  = STABLE;
                    cnt_n    = {CW{1'b0}};
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            default: begin
                state_n = STABLE;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    // Filtered level, edge pulses and wrapping toggle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_out_r      <= 1'b0;
            rise_r       <= 1'b0;
            fall_r       <= 1'b0;
            toggle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            f_out_r <= f_out_r ^ toggle_s;
            rise_r  <= toggle_s & ~f_out_r;
            fall_r  <= toggle_s & f_out_r;
            if (toggle_s) begin
                toggle_cnt_r <= toggle_cnt_r + CNT_W'(1);
            end
        end
    end

`ifdef XOR_FILTER_GLITCH_CNT_EN
    logic             glitch_ev_s;
    logic [CNT_W-1:0] glitch_cnt_r;

    assign glitch_ev_s = (state_r == PENDING) && !diff_s;

    // Saturating count of pulses that returned before qualifying.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            glitch_cnt_r <= {CNT_W{1'b0}};
        end else if (glitch_ev_s && (glitch_cnt_r != {CNT_W{1'b1}})) begin
            glitch_cnt_r <= glitch_cnt_r + CNT_W'(1);
        end
    end

    assign bus.glitch_count = glitch_cnt_r;
`else
    assign bus.glitch_count = {CNT_W{1'b0}};
`endif

    assign bus.f_out        = f_out_r;
    assign bus.rise         = rise_r;
    assign bus.fall         = fall_r;
    assign bus.toggle_count = toggle_cnt_r;
endmodule

// File: tb/tb_xor_glitch_filter.sv
// Randomized and directed bench for xor_glitch_filter against a run-length reference model.
module tb_xor_glitch_filter;

`ifdef XOR_FILTER_GLITCH_CNT_EN
    localparam bit GL_EN = 1'b1;
`else
    localparam bit GL_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic f_in  = 1'b0;
    logic x = 1'b0, y = 1'b0, nx = 1'b1, ny = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rise_a = 0;
    int n_fall_a = 0;

    xor_glitch_filter_if #(.CNT_W(8)) if_a ();
    xor_glitch_filter_if #(.CNT_W(2)) if_b ();
    xor_glitch_filter_if #(.CNT_W(4)) if_c ();

    assign if_a.f_in = f_in;
    assign if_b.f_in = f_in;
    assign if_c.f_in = f_in;

    xor_glitch_filter #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(8)) dut_a (
        .clock (clock), .reset (reset), .bus (if_a.slave));
    xor_glitch_filter #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(2)) dut_b (
        .clock (clock), .reset (reset), .bus (if_b.slave));
    xor_glitch_filter #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .CNT_W(4)) dut_c (
        .clock (clock), .reset (reset), .bus (if_c.slave));

    always #5 clock = ~clock;

    // Reference model: per instance, history of sampled f_in and run length of disagreement.
    int   p_sync [3] = '{2, 2, 3};
    int   p_stab [3] = '{4, 4, 1};
    int   p_cw   [3] = '{8, 2, 4};
    logic [3:0] m_hist [3];
    int   m_fout [3];
    int   m_run  [3];
    int   m_tog  [3];
    int   m_gl   [3];
    int   m_rise [3];
    int   m_fall [3];

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = 4'd0; m_fout[i] = 0; m_run[i] = 0;
            m_tog[i] = 0; m_gl[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int s;
        s = int'(m_hist[i][p_sync[i]-1]);
        m_hist[i] = {m_hist[i][2:0], f_in};
        m_rise[i] = 0;
        m_fall[i] = 0;
        if (s != m_fout[i]) begin
            m_run[i]++;
            if (m_run[i] == p_stab[i]) begin
                m_fout[i] = 1 - m_fout[i];
                if (m_fout[i] == 1) m_rise[i] = 1; else m_fall[i] = 1;
                m_tog[i] = (m_tog[i] + 1) % (1 << p_cw[i]);
                m_run[i] = 0;
            end
        end else begin
            if (m_run[i] > 0 && m_gl[i] < (1 << p_cw[i]) - 1) m_gl[i]++;
            m_run[i] = 0;
        end
    endtask

    task automatic cmp_inst(input int i, input logic fo, input logic r, input logic f,
                            input int tg, input int gl);
        check_val($sformatf("i%0d_f_out", i), int'(fo), m_fout[i]);
        check_val($sformatf("i%0d_rise", i), int'(r), m_rise[i]);
        check_val($sformatf("i%0d_fall", i), int'(f), m_fall[i]);
        check_val($sformatf("i%0d_toggle_count", i), tg, m_tog[i]);
        check_val($sformatf("i%0d_glitch_count", i), gl, GL_EN ? m_gl[i] : 0);
    endtask

    task automatic tick();
        @(posedge clock);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        cmp_inst(0, if_a.f_out, if_a.rise, if_a.fall, int'(if_a.toggle_count), int'(if_a.glitch_count));
        cmp_inst(1, if_b.f_out, if_b.rise, if_b.fall, int'(if_b.toggle_count), int'(if_b.glitch_count));
        cmp_inst(2, if_c.f_out, if_c.rise, if_c.fall, int'(if_c.toggle_count), int'(if_c.glitch_count));
        if (if_a.rise) n_rise_a++;
        if (if_a.fall) n_fall_a++;
    endtask

    // Called just after a clock edge; reset is asserted and released before the next edge.
    task automatic do_reset(input bit check);
        reset = 1'b1;
        model_reset();
        #1;
        if (check) begin
            check_val("rst_f_out", int'(if_a.f_out), 0);
            check_val("rst_rise", int'(if_a.rise), 0);
            check_val("rst_fall", int'(if_a.fall), 0);
            check_val("rst_toggle_count", int'(if_a.toggle_count), 0);
            check_val("rst_glitch_count", int'(if_a.glitch_count), 0);
        end
        f_in = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int kind, hold, start;
        model_reset();
        #2 reset = 1'b0;

        // Clean rise: f_in rises before edge 3, f_out follows at edge 8.
        tick(); tick();
        check_val("init_f_out", int'(if_a.f_out), 0);
        f_in = 1'b1;
        for (int e = 3; e <= 9; e++) begin
            tick();
            check_val($sformatf("rise_lat_f_out_e%0d", e), int'(if_a.f_out), (e >= 8) ? 1 : 0);
            check_val($sformatf("rise_lat_pulse_e%0d", e), int'(if_a.rise), (e == 8) ? 1 : 0);
        end
        check_val("rise_toggle_count", int'(if_a.toggle_count), 1);
        check_val("rise_glitch_count", int'(if_a.glitch_count), 0);

        // Hazard: X,Y switch 10->01 together; the slow inverter leaves a ~3 ns low pulse on F.
        x = 1'b1; y = 1'b0; nx = 1'b0; ny = 1'b1;
        f_in = (x & ny) | (nx & y);
        n_rise_a = 0; n_fall_a = 0;
        fork
            begin
                #7;
                x = 1'b0; y = 1'b1;
                f_in = (x & ny) | (nx & y);
                #3;
                nx = ~x; ny = ~y;
                f_in = (x & ny) | (nx & y);
            end
        join_none
        repeat (10) tick();
        check_val("hazard_f_out", int'(if_a.f_out), 1);
        check_val("hazard_edges", n_rise_a + n_fall_a, 0);
        check_val("hazard_glitch_le1", int'(if_a.glitch_count <= 8'd1), 1);

        // Reset with f_in=1 and f_out=1: outputs clear before any clock edge.
        do_reset(1'b1);

        // Sub-threshold pulse: 3 clocks high.
        repeat (3) tick();
        f_in = 1'b1;
        repeat (3) tick();
        f_in = 1'b0;
        repeat (10) tick();
        check_val("short_f_out", int'(if_a.f_out), 0);
        check_val("short_toggle_count", int'(if_a.toggle_count), 0);
        check_val("short_glitch_count", int'(if_a.glitch_count), GL_EN ? 1 : 0);

        // Boundary pulse: 4 clocks high passes through.
        do_reset(1'b0);
        n_rise_a = 0; n_fall_a = 0;
        f_in = 1'b1;
        repeat (4) tick();
        f_in = 1'b0;
        repeat (10) tick();
        check_val("bound_rises", n_rise_a, 1);
        check_val("bound_falls", n_fall_a, 1);
        check_val("bound_toggle_count", int'(if_a.toggle_count), 2);
        check_val("bound_glitch_count", int'(if_a.glitch_count), 0);

        // Counter limits: 5 toggles then 5 short pulses.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            f_in = ~f_in;
            repeat (8) tick();
        end
        for (int k = 0; k < 5; k++) begin
            f_in = 1'b0;
            repeat (3) tick();
            f_in = 1'b1;
            repeat (6) tick();
        end
        check_val("lim_b_toggle_count", int'(if_b.toggle_count), 1);
        check_val("lim_b_glitch_count", int'(if_b.glitch_count), GL_EN ? 3 : 0);
        check_val("lim_a_toggle_count", int'(if_a.toggle_count), 5);
        check_val("lim_a_glitch_count", int'(if_a.glitch_count), GL_EN ? 5 : 0);

        // Randomized segments: level holds, short async pulses and occasional resets.
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 11));
            if (kind == 0) begin
                do_reset(1'b0);
                tick();
            end else if (kind <= 2) begin
                start = 6 + 2 * int'($urandom_range(0, 1));
                fork
                    begin
                        #(start);
                        f_in = ~f_in;
                        #3;
                        f_in = ~f_in;
                    end
                join_none
                tick(); tick();
            end else begin
                f_in = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 7));
                repeat (hold) tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
